// File: rtl/key_expansion_if.sv
// Command/step inputs and round-key outputs of the AES-128 key schedule engine.
interface key_expansion_if;
    logic [127:0] key_in;
    logic         set_new_key;
    logic         start_enc;
    logic         ready_enc;
    logic [127:0] key_enc;
    logic         start_dec;
    logic         ready_dec;
    logic [127:0] key_dec;

    modport master (
        output key_in, set_new_key, start_enc, ready_enc, start_dec, ready_dec,
        input  key_enc, key_dec
    );

    modport slave (
        input  key_in, set_new_key, start_enc, ready_enc, start_dec, ready_dec,
        output key_enc, key_dec
    );
endinterface

// File: rtl/key_expansion.sv
// AES-128 iterative key schedule: one round key generated per encrypt step,
// all 11 kept so later encrypt passes and the reverse decrypt walk just replay them.
module key_expansion_sbox (
    input  logic [7:0] sub_in,
    output logic [7:0] sub_out
);
    // Entry 0 sits in the top byte, so byte n lives at bits [2047-8n -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub_out = SBOX_TABLE[(11'd2047 - {sub_in, 3'b000}) -: 8];
endmodule

module key_expansion (
    input  logic           clk,
    input  logic           rst,
    key_expansion_if.slave bus
);
    logic [127:0] rk [0:10];
    logic [3:0]   enc_idx;
    logic [3:0]   dec_idx;
    logic         schedule_valid;
    logic         ready_enc_q;
    logic         ready_dec_q;

    logic         enc_step;
    logic         dec_step;
    logic [127:0] cur_key;
    logic [127:0] next_key;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [7:0]   rcon;

    assign enc_step = bus.ready_enc & ~ready_enc_q;
    assign dec_step = bus.ready_dec & ~ready_dec_q;

    assign bus.key_enc = rk[enc_idx];
    assign bus.key_dec = rk[dec_idx];

    assign cur_key  = rk[enc_idx];
    assign {w0, w1, w2, w3} = cur_key;
    assign rot_word = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        key_expansion_sbox u_sbox (
            .sub_in  (rot_word[8*g +: 8]),
            .sub_out (sub_word[8*g +: 8])
        );
    end

    // Rcon for the round being produced, i.e. enc_idx+1.
    always_comb begin
        rcon = 8'h00;
        case (enc_idx)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        t_word   = sub_word ^ {rcon, 24'h000000};
        next_key = '0;
        next_key[127:96] = w0 ^ t_word;
        next_key[95:64]  = w1 ^ next_key[127:96];
        next_key[63:32]  = w2 ^ next_key[95:64];
        next_key[31:0]   = w3 ^ next_key[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk             <= '{default: '0};
            enc_idx        <= '0;
            dec_idx        <= '0;
            schedule_valid <= 1'b0;
            ready_enc_q    <= 1'b0;
            ready_dec_q    <= 1'b0;
        end else begin
            ready_enc_q <= bus.ready_enc;
            ready_dec_q <= bus.ready_dec;
            if (bus.set_new_key) begin
                rk[0]          <= bus.key_in;
                enc_idx        <= '0;
                dec_idx        <= '0;
                schedule_valid <= 1'b0;
            end else begin
                if (bus.start_enc) begin
                    enc_idx <= '0;
                end else if (enc_step && (enc_idx < 4'd10)) begin
                    enc_idx <= enc_idx + 4'd1;
                    // Once all rounds exist, replay passes only move the pointer.
                    if (!schedule_valid) begin
                        rk[enc_idx + 4'd1] <= next_key;
                        if (enc_idx == 4'd9)
                            schedule_valid <= 1'b1;
                    end
                end
                if (schedule_valid) begin
                    if (bus.start_dec)
                        dec_idx <= 4'd10;
                    else if (dec_step && (dec_idx != 4'd0))
                        dec_idx <= dec_idx - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion: a FIPS-197 reference schedule (S-box derived
// from GF(2^8) inversion) predicts both output keys after every clock.
module tb_key_expansion;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_expansion_if bus ();

    key_expansion dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int           id;
        logic [127:0] enc;
        logic [127:0] dec;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           issued = 0;

    logic [7:0]   sbx [256];
    logic [127:0] m_sched [11];
    int           m_enc, m_dec;
    bit           m_valid, m_re_q, m_rd_q;

    localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K1_R2  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    localparam logic [127:0] K1_R3  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    localparam logic [127:0] K1_R5  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    localparam logic [127:0] K1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8).
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbx[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic void expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic void model_step(input bit r, input bit snk, input bit se, input bit re,
                                       input bit sd, input bit rd, input logic [127:0] k);
        bit es = re & ~m_re_q;
        bit ds = rd & ~m_rd_q;
        bit was_valid = m_valid;
        if (r) begin
            expand('0);
            m_enc = 0; m_dec = 0; m_valid = 0; m_re_q = 0; m_rd_q = 0;
            return;
        end
        m_re_q = re;
        m_rd_q = rd;
        if (snk) begin
            expand(k);
            m_enc = 0; m_dec = 0; m_valid = 0;
            return;
        end
        if (se) m_enc = 0;
        else if (es && m_enc < 10) begin
            m_enc++;
            if (m_enc == 10) m_valid = 1;
        end
        if (was_valid) begin
            if (sd) m_dec = 10;
            else if (ds && m_dec > 0) m_dec--;
        end
    endfunction

    task automatic cyc(input bit r, input bit snk, input bit se, input bit re,
                       input bit sd, input bit rd, input logic [127:0] k);
        exp_t e;
        @(negedge clk);
        rst = r; bus.set_new_key = snk; bus.start_enc = se; bus.ready_enc = re;
        bus.start_dec = sd; bus.ready_dec = rd; bus.key_in = k;
        @(posedge clk);
        model_step(r, snk, se, re, sd, rd, k);
        e.id = issued; e.enc = m_sched[m_enc]; e.dec = m_sched[m_dec];
        issued++;
        sb.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, '0);
    endtask

    // Samples 1 time unit after the edge, well before the next negedge drive.
    task automatic chk(input string name, input bit sel_dec, input logic [127:0] exp_v);
        logic [127:0] act;
        #1;
        act = sel_dec ? bus.key_dec : bus.key_enc;
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.key_enc !== e.enc || bus.key_dec !== e.dec) begin
                    errors++;
                    $display("FAIL sb[%0d]: key_enc got %h expected %h, key_dec got %h expected %h",
                             e.id, bus.key_enc, e.enc, bus.key_dec, e.dec);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; bus.set_new_key = 0; bus.start_enc = 0; bus.ready_enc = 0;
        bus.start_dec = 0; bus.ready_dec = 0; bus.key_in = '0;
        build_sbox();
        expand('0);
        m_enc = 0; m_dec = 0; m_valid = 0; m_re_q = 0; m_rd_q = 0;

        cyc(1, 0, 0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, 0, '0);
        chk("reset_enc", 0, '0);
        cyc(0, 1, 0, 0, 0, 0, K1);
        chk("k1_load", 0, K1);

        for (int p = 1; p <= 11; p++) begin
            cyc(0, 0, 0, 1, 0, 0, '0);
            if (p == 1) chk("k1_r1", 0, K1_R1);
            if (p == 2) chk("k1_r2", 0, K1_R2);
            if (p == 3) chk("k1_r3", 0, K1_R3);
            if (p >= 10) chk("k1_r10_sat", 0, K1_R10);
            idle();
        end

        cyc(0, 0, 0, 0, 1, 0, '0);
        chk("dec_start_r10", 1, K1_R10);
        for (int p = 1; p <= 12; p++) begin
            cyc(0, 0, 0, 0, 0, 1, '0);
            if (p >= 10) chk("dec_floor_r0", 1, K1);
            idle();
        end

        cyc(0, 0, 1, 0, 0, 0, '0);
        chk("restart_enc_r0", 0, K1);
        for (int p = 1; p <= 5; p++) begin
            cyc(0, 0, 0, 1, 0, 0, '0);
            idle();
        end
        chk("replay_r5", 0, K1_R5);
        repeat (20) cyc(0, 0, 0, 1, 0, 0, '0);
        idle();

        cyc(0, 1, 0, 0, 0, 0, K2);
        cyc(0, 0, 0, 1, 0, 0, '0);
        chk("k2_r1", 0, K2_R1);
        idle();
        cyc(0, 0, 0, 0, 1, 0, '0);
        chk("dec_start_invalid", 1, K2);
        cyc(0, 0, 0, 0, 0, 1, '0);
        chk("dec_step_invalid", 1, K2);
        idle();
        for (int p = 2; p <= 10; p++) begin
            cyc(0, 0, 0, 1, 0, 0, '0);
            idle();
        end
        chk("k2_r10", 0, K2_R10);
        cyc(0, 0, 0, 0, 1, 0, '0);
        chk("k2_dec_r10", 1, K2_R10);

        cyc(0, 1, 0, 1, 0, 0, K1);
        chk("prio_load_over_step", 0, K1);
        idle();
        cyc(0, 0, 0, 1, 0, 0, '0);
        idle();
        cyc(0, 0, 0, 1, 0, 0, '0);
        idle();
        cyc(0, 0, 1, 1, 0, 0, '0);
        chk("prio_start_over_step", 0, K1);
        idle();
        cyc(0, 0, 0, 1, 0, 0, '0);
        idle();
        cyc(1, 0, 0, 0, 0, 0, '0);
        chk("rst_mid_enc", 0, '0);
        chk("rst_mid_dec", 1, '0);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 60) == 0, ($urandom % 40) == 0, ($urandom % 25) == 0,
                1'($urandom), ($urandom % 20) == 0, 1'($urandom),
                {$urandom, $urandom, $urandom, $urandom});
        end
        idle();

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_expansion.md
Name: key_expansion

Overview:
- AES-128 iterative key-schedule engine feeding the encrypt and decrypt round datapaths.
- Loads a 128-bit master key and generates round keys 1..10 one per encrypt-step request.
- Stores all 11 round keys so later passes replay them without recomputation.
- Provides an independent reverse walk (round 10 down to 0) for decryption.

Parameters:
- None. AES-128 only: 11 round keys, fixed Rcon table.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- key_in  input  128  master key; bits [127:96] = w0, byte 0 at MSB (FIPS-197 order)
- set_new_key  input  1  level; load key_in as round 0 and invalidate the schedule
- start_enc  input  1  level; rewind encrypt pointer to round 0
- ready_enc  input  1  step request; a rising edge advances the encrypt pointer
- key_enc  output  128  round key at the encrypt pointer
- start_dec  input  1  level; set decrypt pointer to round 10
- ready_dec  input  1  step request; a rising edge moves the decrypt pointer back one round
- key_dec  output  128  round key at the decrypt pointer

Behaviour:
- State:
  - rk[0..10], 11 x 128-bit registers
  - enc_idx and dec_idx, 0..10
  - schedule_valid flag
  - ready_enc_q and ready_dec_q edge-detect registers
- Reset: all rk = 0, enc_idx = dec_idx = 0, schedule_valid = 0, edge registers = 0. Outputs therefore read key_enc = key_dec = 0.
- Outputs: key_enc = rk[enc_idx] and key_dec = rk[dec_idx], combinational reads of registered state. There is no extra output register.
- Edge detection: enc_step = ready_enc & ~ready_enc_q, sampled each clk. ready_dec uses the same form. A held-high ready produces exactly one step.
- Latency: a command or step sampled at clock edge N is visible on the outputs after edge N.
- Encrypt-side priority per cycle, highest first:
  1. set_new_key: rk[0] <= key_in; enc_idx <= 0; dec_idx <= 0; schedule_valid <= 0.
  2. start_enc: enc_idx <= 0. rk and schedule_valid are unchanged, so no recompute occurs.
  3. enc_step with enc_idx < 10:
     - enc_idx <= enc_idx+1.
     - If schedule_valid = 0, also write rk[enc_idx+1] <= next_round(rk[enc_idx], Rcon[enc_idx+1]).
     - When that write targets rk[10], set schedule_valid <= 1.
     - If schedule_valid = 1, only the pointer moves.
  4. enc_step with enc_idx = 10: ignored; the pointer saturates.
- Decrypt side, evaluated in the same cycle:
  - set_new_key overrides the decrypt side.
  - start_dec: dec_idx <= 10. Ignored while schedule_valid = 0.
  - dec_step (lower priority than start_dec): if schedule_valid = 1 and dec_idx > 0, dec_idx <= dec_idx-1.
  - dec_step at 0, or while the schedule is invalid: ignored.
- The encrypt and decrypt pointers are independent and may move in the same cycle.
- next_round (standard AES-128 schedule), with words w0..w3 of the previous key:
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36
  - SubWord uses 4 combinational AES S-box instances (FIPS-197 table).
- Single-cycle combinational round; no multicycle paths.
- set_new_key mid-expansion: abandon progress and restart from the new rk[0]. Stale rk[1..10] values remain but are unreachable until regenerated.
- Reset asserted mid-operation returns the block to the reset state on the next edge.

Test Plan:
- Reset, then set_new_key with key_in = 000102030405060708090a0b0c0d0e0f -> key_enc = 000102030405060708090a0b0c0d0e0f.
- Continuing: 10 ready_enc pulses -> key_enc sequence:
  - r1 d6aa74fdd2af72fadaa678f1d6ab76fe
  - r2 b692cf0b643dbdf1be9bc5006830b3fe
  - r3 b6ff744ed2c2c9bf6c590cbf0469bf41
  - r10 13111d7fe3944a17f307a78b4d2b30c5
  - An 11th pulse leaves key_enc at r10.
- Continuing: start_dec, then 10 ready_dec pulses -> key_dec = r10 immediately after start_dec, then r9 … down to r0 = 000102…0f. Further pulses hold r0.
- Continuing: start_enc plus 5 ready_enc pulses -> key_enc = r0 then r1..r5 (r5 3caaa3e8a99f9deb50f3af57adf622aa), with rk unchanged. Also hold ready_enc high for many cycles -> exactly one step.
- New key 2b7e151628aed2a6abf7158809cf4f3c -> r1 a0fafe1788542cb123a339392a6c7605, r10 d014f9a8c9ee2589e13f0cc8b6630ca6. Issuing start_dec before r10 is generated -> ignored; key_dec stays at rk[0].
- Priority checks:
  - set_new_key and ready_enc in the same cycle -> load wins, enc_idx = 0.
  - start_enc and ready_enc edge together -> enc_idx = 0.
  - rst mid-walk -> all outputs 0.
